// File: rtl/bsg_level_shift_iso_sequencer.sv
// bsg_level_shift_iso_sequencer
//   Upstream companion of the isolating level-shift source cell. Sequences the
//   v0-side power domain (off -> wait for supply -> settle -> active -> drain ->
//   isolate) and drives the shifter enable from iso_en_o. A single valid/ready
//   register buffers one v0 word toward the shifter, and isolation is only
//   re-applied once that register is empty (or the far supply has been lost).
module bsg_level_shift_iso_sequencer #(
   parameter int width_p         = 128,
   parameter int settle_cycles_p = 16
) (
   input  logic               clk_i,
   input  logic               reset_n_i,

   input  logic               v0_v_i,
   input  logic [width_p-1:0] v0_data_i,
   output logic               v0_ready_o,

   output logic               v1_v_o,
   output logic [width_p-1:0] v1_data_o,
   input  logic               v1_ready_i,

   output logic               iso_en_o,

   input  logic               pwr_up_req_i,
   input  logic               pwr_down_req_i,
   input  logic               pwr_good_i,
   output logic               pwr_off_o,
   output logic               fault_o
);

   // Counter only has to hold settle_cycles_p-1; keep at least one bit.
   localparam int cnt_w_lp = (settle_cycles_p > 1) ? $clog2(settle_cycles_p) : 1;
   localparam logic [cnt_w_lp-1:0] settle_load_lp = cnt_w_lp'(settle_cycles_p - 1);

   typedef enum logic [2:0] {
      e_off,
      e_wait_pg,
      e_settle,
      e_active,
      e_drain,
      e_iso
   } state_e;

   state_e              state_r, state_n;
   logic [cnt_w_lp-1:0] cnt_r, cnt_n;
   logic                v1_v_r;
   logic [width_p-1:0]  v1_data_r;
   logic                fault_r;
   logic                pg_lost;
   logic                accept;

   // Next-state and settle-counter decode; supply loss and down requests take priority.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path leaves it
      // unassigned and no latch is inferred.
      state_n = state_r;
      cnt_n   = cnt_r;
      pg_lost = 1'b0;
      unique case (state_r)
         e_off: begin
            if (pwr_up_req_i & ~pwr_down_req_i) state_n = e_wait_pg;
         end
         e_wait_pg: begin
            if (pwr_down_req_i) begin
               state_n = e_off;
            end else if (pwr_good_i) begin
               state_n = e_settle;
               cnt_n   = settle_load_lp;
            end
         end
         e_settle: begin
            if (~pwr_good_i) begin
               state_n = e_wait_pg;
            end else if (pwr_down_req_i) begin
               state_n = e_off;
            end else if (cnt_r == '0) begin
               state_n = e_active;
            end else begin
               cnt_n = cnt_r - 1'b1;
            end
         end
         e_active: begin
            if (~pwr_good_i) begin
               state_n = e_iso;
               pg_lost = 1'b1;
            end else if (pwr_down_req_i) begin
               state_n = e_drain;
            end
         end
         e_drain: begin
            if (~pwr_good_i) begin
               state_n = e_iso;
               pg_lost = 1'b1;
            end else if (~v1_v_r | v1_ready_i) begin
               state_n = e_iso;
            end
         end
         e_iso: begin
            state_n = e_off;
         end
         default: begin
            state_n = e_off;
         end
      endcase
   end

   // State and settle-counter registers; reset lands in OFF with isolation applied.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r <= e_off;
         cnt_r   <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register
         // samples pre-edge values regardless of block ordering.
         state_r <= state_n;
         cnt_r   <= cnt_n;
      end
   end

   // Ready depends on state and the consumer only, never on v0_v_i.
   assign accept = v0_v_i & v0_ready_o;

   // Buffer register: supply loss discards the word, an accept replaces it (no bubble
   // on simultaneous drain), otherwise a consumer handshake empties it.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         v1_v_r    <= 1'b0;
         // NOTE: the data word is reset too so the shifter sees a defined value
         // straight out of reset; it is a single register, not a memory array.
         v1_data_r <= '0;
      end else if (pg_lost) begin
         v1_v_r    <= 1'b0;
      end else if (accept) begin
         v1_v_r    <= 1'b1;
         v1_data_r <= v0_data_i;
      end else if (v1_ready_i) begin
         v1_v_r    <= 1'b0;
      end
   end

   // Sticky fault flag: set whenever the far supply drops while data may be in flight.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         fault_r <= 1'b0;
      end else if (pg_lost) begin
         fault_r <= 1'b1;
      end
   end

   assign v0_ready_o = (state_r == e_active) & (~v1_v_r | v1_ready_i);
   assign iso_en_o   = (state_r == e_active) | (state_r == e_drain);
   assign pwr_off_o  = (state_r == e_off);
   assign v1_v_o     = v1_v_r;
   assign v1_data_o  = v1_data_r;
   assign fault_o    = fault_r;

endmodule
